// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache sitting between
// the fetch unit and memctrl. Hits deliver one cycle after the request; misses
// run the icache_in / icache_received / icache_task_out handshake, fill the
// line and then deliver the word unless a flush cancelled it.
// Optional feature: define ICACHE_STAT_EN to add hit_count / miss_count outputs.
module icache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        busy,
  output logic        icache_in,
  output logic [31:0] icache_address_in,
  input  logic        icache_received,
  input  logic        icache_task_out,
  input  logic [31:0] value_load
`ifdef ICACHE_STAT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES    = 1 << INDEX_BITS;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Line storage: only the valid bits need a reset value.
  logic [LINES-1:0]    valid_r;
  logic [TAG_BITS-1:0] tag_r  [LINES];
  logic [31:0]         data_r [LINES];

  logic [1:0]  state_r;
  logic [31:0] miss_pc_r;
  logic        cancel_r;
  logic        inst_valid_r;
  logic [31:0] inst_out_r;
  logic [31:0] inst_pc_r;
  logic        busy_r;
  logic        req_r;
  logic [31:0] req_addr_r;

  logic [INDEX_BITS-1:0] idx_s;
  logic [INDEX_BITS-1:0] miss_idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [TAG_BITS-1:0]   miss_tag_s;
  logic [31:0]           pc_aligned_s;
  logic                  lookup_s;
  logic                  hit_s;
  logic                  fill_s;
  logic                  deliver_s;
  logic                  unused_s;

  // Address split, lookup and fill/delivery qualifiers.
  always_comb begin
    idx_s        = fetch_pc[2 +: INDEX_BITS];
    tag_s        = fetch_pc[31 -: TAG_BITS];
    pc_aligned_s = {fetch_pc[31:2], 2'b00};
    miss_idx_s   = miss_pc_r[2 +: INDEX_BITS];
    miss_tag_s   = miss_pc_r[31 -: TAG_BITS];
    lookup_s     = (state_r == ST_IDLE) && fetch_valid && !flush;
    hit_s        = valid_r[idx_s] && (tag_r[idx_s] == tag_s);
    // task_out is only meaningful once the request has been accepted
    fill_s       = (state_r == ST_WAIT) && icache_task_out;
    // a flush arriving together with the completing task_out still suppresses delivery
    deliver_s    = fill_s && !cancel_r && !flush;
  end

  // Byte-offset bits of the PC are never used by a word-granular cache.
  assign unused_s = ^{fetch_pc[1:0], miss_pc_r[1:0]};

  // Controller state, valid bits and registered fetch-side/memctrl-side outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r      <= ST_IDLE;
      valid_r      <= '0;
      miss_pc_r    <= 32'd0;
      cancel_r     <= 1'b0;
      inst_valid_r <= 1'b0;
      inst_out_r   <= 32'd0;
      inst_pc_r    <= 32'd0;
      busy_r       <= 1'b0;
      req_r        <= 1'b0;
      req_addr_r   <= 32'd0;
    end else if (rdy_in) begin
      inst_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cancel_r <= 1'b0;
          if (lookup_s) begin
            if (hit_s) begin
              inst_valid_r <= 1'b1;
              inst_out_r   <= data_r[idx_s];
              inst_pc_r    <= pc_aligned_s;
            end else begin
              miss_pc_r  <= pc_aligned_s;
              req_r      <= 1'b1;
              req_addr_r <= pc_aligned_s;
              busy_r     <= 1'b1;
              state_r    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (flush) begin
            cancel_r <= 1'b1;
          end
          if (icache_received) begin
            req_r   <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush) begin
            cancel_r <= 1'b1;
          end
          if (fill_s) begin
            valid_r[miss_idx_s] <= 1'b1;
            if (deliver_s) begin
              inst_valid_r <= 1'b1;
              inst_out_r   <= value_load;
              inst_pc_r    <= miss_pc_r;
            end
            busy_r   <= 1'b0;
            cancel_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Line data and tag write on fill; the line is kept even when delivery is cancelled.
  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && fill_s) begin
      data_r[miss_idx_s] <= value_load;
      tag_r[miss_idx_s]  <= miss_tag_s;
    end
  end

  assign inst_valid        = inst_valid_r;
  assign inst_out          = inst_out_r;
  assign inst_pc           = inst_pc_r;
  assign busy              = busy_r;
  assign icache_in         = req_r;
  assign icache_address_in = req_addr_r;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  // Hit/miss statistics, counted on IDLE lookups only; wrap naturally at 2**32.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
    end else if (rdy_in && lookup_s) begin
      if (hit_s) begin
        hit_count_r <= hit_count_r + 32'd1;
      end else begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_r;
  assign miss_count = miss_count_r;
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed plus randomized stimulus for icache. The bench plays the
// memctrl side itself and predicts hits/misses from a line-level model
// (valid/tag/data per index) kept as plain arrays.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_pc = 32'd0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        busy;
  logic        icache_in;
  logic [31:0] icache_address_in;
  logic        icache_received = 1'b0;
  logic        icache_task_out = 1'b0;
  logic [31:0] value_load = 32'd0;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk_in = ~clk_in;

  icache dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .flush(flush),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .busy(busy),
    .icache_in(icache_in), .icache_address_in(icache_address_in),
    .icache_received(icache_received), .icache_task_out(icache_task_out),
    .value_load(value_load)
`ifdef ICACHE_STAT_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int total = 0;
  int passed = 0;
  int fails = 0;
  int iv_count = 0;
  int req_count = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  // Reference model: one entry per cache line.
  bit          ref_valid [64];
  logic [23:0] ref_tag   [64];
  logic [31:0] ref_data  [64];

  // Count delivered words and request cycles, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (inst_valid) iv_count <= iv_count + 1;
    if (icache_in) req_count <= req_count + 1;
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) ref_valid[i] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // One fetch; on a miss the bench answers as memctrl.
  // flush_at: 0 none, 1 in the received cycle, 2 first WAIT cycle, 3 with task_out.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] val,
                           input int req_wait, input int wait_cyc, input int flush_at,
                           input bit stale, input int stall);
    logic [5:0]  idx;
    logic [23:0] tg;
    logic [31:0] apc;
    bit          hit;
    bit          deliver;
    int          iv0;
    int          rq0;
    idx = pc[7:2];
    tg  = pc[31:8];
    apc = {pc[31:2], 2'b00};
    hit = ref_valid[idx] && (ref_tag[idx] == tg);
    iv0 = iv_count;
    rq0 = req_count;
    fetch_valid = 1'b1;
    fetch_pc = pc;
    step();
    fetch_valid = 1'b0;
    if (hit) begin
      exp_hits++;
      chkb("hit_valid", inst_valid, 1'b1);
      chk("hit_data", inst_out, ref_data[idx]);
      chk("hit_pc", inst_pc, apc);
      chkb("hit_busy", busy, 1'b0);
      step();
      chkb("hit_pulse", inst_valid, 1'b0);
      chk("hit_noreq", 32'(req_count - rq0), 32'd0);
      chk("hit_count", 32'(iv_count - iv0), 32'd1);
    end else begin
      exp_misses++;
      deliver = (flush_at == 0);
      chkb("miss_noinst", inst_valid, 1'b0);
      chkb("miss_busy", busy, 1'b1);
      chkb("miss_req", icache_in, 1'b1);
      chk("miss_addr", icache_address_in, apc);
      if (stale) begin
        icache_task_out = 1'b1;
        value_load = 32'hDEAD_BEEF;
      end
      if (stall > 0) begin
        rdy_in = 1'b0;
        icache_received = 1'b1;
        fetch_valid = 1'b1;
        fetch_pc = pc ^ 32'h0000_0040;
        for (int i = 0; i < stall; i++) begin
          step();
          chkb("stall_req", icache_in, 1'b1);
          chkb("stall_busy", busy, 1'b1);
          chk("stall_addr", icache_address_in, apc);
        end
        rdy_in = 1'b1;
        icache_received = 1'b0;
        fetch_valid = 1'b0;
      end
      for (int i = 0; i < req_wait; i++) begin
        fetch_valid = 1'($urandom_range(0, 1));
        fetch_pc = $urandom;
        step();
        chkb("req_hold", icache_in, 1'b1);
        chk("req_addr", icache_address_in, apc);
      end
      fetch_valid = 1'b0;
      icache_received = 1'b1;
      flush = (flush_at == 1);
      step();
      icache_received = 1'b0;
      flush = 1'b0;
      icache_task_out = 1'b0;
      value_load = 32'd0;
      chkb("recv_drop", icache_in, 1'b0);
      chkb("recv_busy", busy, 1'b1);
      for (int i = 0; i < wait_cyc; i++) begin
        flush = (flush_at == 2) && (i == 0);
        step();
        flush = 1'b0;
        chkb("wait_busy", busy, 1'b1);
        chkb("wait_noinst", inst_valid, 1'b0);
      end
      icache_task_out = 1'b1;
      value_load = val;
      flush = (flush_at == 3) || ((flush_at == 2) && (wait_cyc == 0));
      step();
      icache_task_out = 1'b0;
      flush = 1'b0;
      value_load = $urandom;
      ref_valid[idx] = 1'b1;
      ref_tag[idx] = tg;
      ref_data[idx] = val;
      chkb("fill_valid", inst_valid, deliver);
      if (deliver) begin
        chk("fill_data", inst_out, val);
        chk("fill_pc", inst_pc, apc);
      end
      chkb("fill_busy", busy, 1'b0);
      step();
      chkb("fill_pulse", inst_valid, 1'b0);
      chk("fill_count", 32'(iv_count - iv0), deliver ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    int iv0;
    logic [31:0] rpc;
    clear_model();

    // Reset wins over a concurrent fetch and handshake.
    fetch_valid = 1'b1;
    fetch_pc = 32'h0000_1000;
    icache_received = 1'b1;
    step();
    step();
    chkb("rst_inst_valid", inst_valid, 1'b0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_req", icache_in, 1'b0);
    chk("rst_addr", icache_address_in, 32'd0);
    rst_in = 1'b0;
    fetch_valid = 1'b0;
    icache_received = 1'b0;
    step();

    // Cold miss, then hit after fill.
    run_fetch(32'h0000_1000, 32'h0050_0093, 2, 3, 0, 1'b0, 0);
    run_fetch(32'h0000_1000, 32'h0, 0, 0, 0, 1'b0, 0);

    // Conflict on index 0: new tag evicts, old tag misses again.
    run_fetch(32'h0000_1100, $urandom, 1, 1, 0, 1'b0, 0);
    run_fetch(32'h0000_1000, $urandom, 0, 2, 0, 1'b0, 0);
    run_fetch(32'h0000_1000, 32'h0, 0, 0, 0, 1'b0, 0);

    // Flush during WAIT: line filled, no delivery; next fetch hits.
    run_fetch(32'h0000_2000, $urandom, 1, 3, 2, 1'b0, 0);
    run_fetch(32'h0000_2000, 32'h0, 0, 0, 0, 1'b0, 0);

    // Flush in IDLE drops the request, even for a cached line.
    iv0 = iv_count;
    fetch_valid = 1'b1;
    fetch_pc = 32'h0000_2000;
    flush = 1'b1;
    step();
    fetch_valid = 1'b0;
    flush = 1'b0;
    chkb("idle_flush_inst", inst_valid, 1'b0);
    chkb("idle_flush_busy", busy, 1'b0);
    chkb("idle_flush_req", icache_in, 1'b0);
    step();
    chk("idle_flush_count", 32'(iv_count - iv0), 32'd0);

    // Flush with the completing task_out, and flush in the received cycle.
    run_fetch(32'h0000_2404, $urandom, 0, 2, 3, 1'b0, 0);
    run_fetch(32'h0000_2404, 32'h0, 0, 0, 0, 1'b0, 0);
    run_fetch(32'h0000_2808, $urandom, 2, 1, 1, 1'b0, 0);
    run_fetch(32'h0000_2808, 32'h0, 0, 0, 0, 1'b0, 0);

    // Stale task_out through REQ and the received cycle.
    run_fetch(32'h0000_300C, 32'h1234_5678, 2, 2, 0, 1'b1, 0);
    run_fetch(32'h0000_300C, 32'h0, 0, 0, 0, 1'b0, 0);

    // Back-to-back hits, one word per cycle.
    fetch_valid = 1'b1;
    fetch_pc = 32'h0000_2000;
    step();
    chkb("b2b_v0", inst_valid, 1'b1);
    chk("b2b_d0", inst_out, ref_data[0]);
    chk("b2b_pc0", inst_pc, 32'h0000_2000);
    fetch_pc = 32'h0000_2404;
    step();
    fetch_valid = 1'b0;
    chkb("b2b_v1", inst_valid, 1'b1);
    chk("b2b_d1", inst_out, ref_data[1]);
    chk("b2b_pc1", inst_pc, 32'h0000_2404);
    step();
    chkb("b2b_end", inst_valid, 1'b0);
    exp_hits += 2;

    // rdy_in low for 5 cycles mid-REQ.
    run_fetch(32'h0000_3410, $urandom, 1, 1, 0, 1'b0, 5);
    run_fetch(32'h0000_3410, 32'h0, 0, 0, 0, 1'b0, 0);

    // Reset mid-WAIT, colliding with task_out.
    fetch_valid = 1'b1;
    fetch_pc = 32'h0000_3814;
    step();
    fetch_valid = 1'b0;
    icache_received = 1'b1;
    step();
    icache_received = 1'b0;
    step();
    rst_in = 1'b1;
    icache_task_out = 1'b1;
    value_load = 32'hCAFE_F00D;
    step();
    rst_in = 1'b0;
    icache_task_out = 1'b0;
    chkb("wrst_inst_valid", inst_valid, 1'b0);
    chk("wrst_inst_out", inst_out, 32'd0);
    chk("wrst_inst_pc", inst_pc, 32'd0);
    chkb("wrst_busy", busy, 1'b0);
    chkb("wrst_req", icache_in, 1'b0);
    chk("wrst_addr", icache_address_in, 32'd0);
    clear_model();
    step();
    run_fetch(32'h0000_2000, $urandom, 0, 1, 0, 1'b0, 0);

    // Randomized traffic over a few indices and tags.
    for (int n = 0; n < 40; n++) begin
      rpc = 32'h0004_0000;
      rpc[9:8] = 2'($urandom_range(0, 2));
      rpc[3:2] = 2'($urandom_range(0, 3));
      rpc[1:0] = 2'($urandom_range(0, 3));
      run_fetch(rpc, $urandom, $urandom_range(0, 3), $urandom_range(0, 4),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

`ifdef ICACHE_STAT_EN
    chk("stat_hits", hit_count, 32'(exp_hits));
    chk("stat_misses", miss_count, 32'(exp_misses));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
